// File: rtl/test_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// test_sequencer_pkg
// Shared definitions for the test sequencer: one-hot state encoding, the width
// of the measured-delay field used to load the skip counter, and a helper that
// forms the skip load value.
// Ports: none (package).
// -----------------------------------------------------------------------------
package test_sequencer_pkg;

   // One-hot run-controller states.
   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_CAL  = 5'b00010,
      ST_SKIP = 5'b00100,
      ST_RUN  = 5'b01000,
      ST_DONE = 5'b10000
   } state_e;

   // Only the low bits of the measured DUT delay are meaningful latency.
   localparam int DELAY_FIELD_W = 16;
   // One extra bit so delay + settle never wraps the skip counter.
   localparam int SKIP_W        = DELAY_FIELD_W + 1;

   // Cycles to skip after calibration: measured latency plus settle margin.
   function automatic logic [SKIP_W-1:0] skip_load(
      input logic [DELAY_FIELD_W-1:0] delay,
      input int unsigned              settle
   );
      return SKIP_W'(delay) + SKIP_W'(settle);
   endfunction

endpackage

// File: rtl/test_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// test_sequencer_sat_counter
// Saturating up-counter used for the mismatch count. Holds at all-ones and
// never wraps. Synchronous clear has priority over increment.
// Ports:
//   clk_i    in  1  clock, rising edge
//   rst_i    in  1  asynchronous active-high reset
//   clr_i    in  1  synchronous clear
//   inc_i    in  1  increment request
//   count_o  out W  current count
// -----------------------------------------------------------------------------
module test_sequencer_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of block ordering in simulation.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (inc_i && !(&count_q)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/test_sequencer.sv
// -----------------------------------------------------------------------------
// test_sequencer
// Run controller for the arithmetic testbench. A start pulse latches the test
// count, waits for the driver's DUT-delay measurement (with timeout), skips the
// pipeline fill, then compares DUT output against the aligned reference for the
// programmed number of cycles and reports pass/fail.
//
// Optional build macro: FAIL_CAPTURE_EN adds first-mismatch capture ports.
//
// Ports:
//   clk_dut       in  1      clock, rising edge
//   reset         in  1      asynchronous active-high reset
//   i_start       in  1      start/restart pulse (honoured in IDLE and DONE)
//   i_num_tests   in  CNT_W  number of comparisons, latched on accepted start
//   i_dut_delay   in  WIDTH  measured DUT latency, all-ones = not measured yet
//   i_dut_out     in  WIDTH  DUT result
//   i_ref_out     in  WIDTH  reference result aligned to i_dut_out
//   i_delayed_a   in  WIDTH  operand A aligned to i_dut_out
//   i_delayed_b   in  WIDTH  operand B aligned to i_dut_out
//   o_busy        out 1      in CAL, SKIP or RUN
//   o_done        out 1      in DONE, held until the next start
//   o_pass        out 1      with o_done: no mismatches and no timeout
//   o_timeout     out 1      calibration timed out
//   o_test_count  out CNT_W  comparisons performed
//   o_err_count   out ERR_W  mismatches, saturating
//   (FAIL_CAPTURE_EN) o_fail_a/o_fail_b/o_fail_out/o_fail_ref (WIDTH),
//                     o_fail_idx (CNT_W): data of the first mismatch in a run
// -----------------------------------------------------------------------------
module test_sequencer
   import test_sequencer_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CNT_W  = 32,
   parameter int ERR_W  = 16,
   parameter int SETTLE = 4,
   parameter int TMO_W  = 18
) (
   input  logic             clk_dut,
   input  logic             reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_num_tests,
   input  logic [WIDTH-1:0] i_dut_delay,
   input  logic [WIDTH-1:0] i_dut_out,
   input  logic [WIDTH-1:0] i_ref_out,
   input  logic [WIDTH-1:0] i_delayed_a,
   input  logic [WIDTH-1:0] i_delayed_b,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_test_count,
   output logic [ERR_W-1:0] o_err_count
`ifdef FAIL_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] o_fail_a,
   output logic [WIDTH-1:0] o_fail_b,
   output logic [WIDTH-1:0] o_fail_out,
   output logic [WIDTH-1:0] o_fail_ref,
   output logic [CNT_W-1:0] o_fail_idx
`endif
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    num_q, num_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [SKIP_W-1:0]   skip_q, skip_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                timeout_q, timeout_d;
   logic                start_accept;
   logic                err_clr;
   logic                err_inc;
   logic                mismatch;
   logic                delay_known;
   logic [ERR_W-1:0]    err_count;

   assign mismatch    = (i_dut_out != i_ref_out);
   assign delay_known = ~(&i_dut_delay);

   // -------------------------------------------------------------------------
   // Next-state and counter logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      num_d        = num_q;
      count_d      = count_q;
      skip_d       = skip_q;
      tmo_d        = tmo_q;
      timeout_d    = timeout_q;
      start_accept = 1'b0;
      err_clr      = 1'b0;
      err_inc      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               start_accept = 1'b1;
               num_d        = i_num_tests;
               count_d      = '0;
               skip_d       = '0;
               tmo_d        = '0;
               timeout_d    = 1'b0;
               err_clr      = 1'b1;
               // A zero-length run completes immediately as a pass.
               if (i_num_tests == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CAL;
               end
            end
         end

         ST_CAL: begin
            tmo_d = tmo_q + TMO_W'(1);
            // A valid measurement wins over a timeout in the same cycle.
            if (delay_known) begin
               skip_d  = skip_load(i_dut_delay[DELAY_FIELD_W-1:0], SETTLE);
               state_d = ST_SKIP;
            end else if (&tmo_d) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end

         ST_SKIP: begin
            if (skip_q == '0) begin
               state_d = ST_RUN;
            end else begin
               skip_d = skip_q - SKIP_W'(1);
            end
         end

         ST_RUN: begin
            count_d = count_q + CNT_W'(1);
            err_inc = mismatch;
            if (count_d == num_q) begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_dut or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         count_q   <= '0;
         skip_q    <= '0;
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         count_q   <= count_d;
         skip_q    <= skip_d;
         tmo_q     <= tmo_d;
         timeout_q <= timeout_d;
      end
   end

   test_sequencer_sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk_i   (clk_dut),
      .rst_i   (reset),
      .clr_i   (err_clr),
      .inc_i   (err_inc),
      .count_o (err_count)
   );

   // -------------------------------------------------------------------------
   // Outputs: decoded only from flops, no input-to-output paths
   // -------------------------------------------------------------------------
   assign o_busy       = (state_q == ST_CAL) || (state_q == ST_SKIP) || (state_q == ST_RUN);
   assign o_done       = (state_q == ST_DONE);
   assign o_pass       = o_done && (err_count == '0) && !timeout_q;
   assign o_timeout    = timeout_q;
   assign o_test_count = count_q;
   assign o_err_count  = err_count;

`ifdef FAIL_CAPTURE_EN
   logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_out_q, fail_ref_q;
   logic [CNT_W-1:0] fail_idx_q;

   // The mismatch counter saturates and never returns to zero within a run,
   // so a zero count marks "no mismatch captured yet".
   always_ff @(posedge clk_dut or posedge reset) begin
      if (reset) begin
         fail_a_q   <= '0;
         fail_b_q   <= '0;
         fail_out_q <= '0;
         fail_ref_q <= '0;
         fail_idx_q <= '0;
      end else if (start_accept) begin
         fail_a_q   <= '0;
         fail_b_q   <= '0;
         fail_out_q <= '0;
         fail_ref_q <= '0;
         fail_idx_q <= '0;
      end else if ((state_q == ST_RUN) && mismatch && (err_count == '0)) begin
         fail_a_q   <= i_delayed_a;
         fail_b_q   <= i_delayed_b;
         fail_out_q <= i_dut_out;
         fail_ref_q <= i_ref_out;
         fail_idx_q <= count_q;
      end
   end

   assign o_fail_a   = fail_a_q;
   assign o_fail_b   = fail_b_q;
   assign o_fail_out = fail_out_q;
   assign o_fail_ref = fail_ref_q;
   assign o_fail_idx = fail_idx_q;
`else
   // Operand buses only feed the capture registers.
   logic unused_operands;
   assign unused_operands = ^{i_delayed_a, i_delayed_b, start_accept};
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_test_sequencer
// Self-checking bench for test_sequencer. Each run pushes its expected result
// into a scoreboard queue; a monitor pops and compares when o_done appears.
// Small TMO_W and ERR_W keep the timeout and saturation cases short.
// -----------------------------------------------------------------------------
module tb_test_sequencer;

   localparam int WIDTH  = 32;
   localparam int CNT_W  = 16;
   localparam int ERR_W  = 4;
   localparam int SETTLE = 4;
   localparam int TMO_W  = 8;
   localparam int MAXN   = 256;
   localparam int BUDGET = 3000;
   localparam int TMO_CYCLES = (1 << TMO_W) - 1;
   localparam int ERR_MAX    = (1 << ERR_W) - 1;

   logic             clk_dut = 1'b0;
   logic             reset;
   logic             i_start;
   logic [CNT_W-1:0] i_num_tests;
   logic [WIDTH-1:0] i_dut_delay, i_dut_out, i_ref_out, i_delayed_a, i_delayed_b;
   logic             o_busy, o_done, o_pass, o_timeout;
   logic [CNT_W-1:0] o_test_count;
   logic [ERR_W-1:0] o_err_count;
   logic [WIDTH-1:0] o_fail_a, o_fail_b, o_fail_out, o_fail_ref;
   logic [CNT_W-1:0] o_fail_idx;

   test_sequencer #(
      .WIDTH (WIDTH), .CNT_W (CNT_W), .ERR_W (ERR_W), .SETTLE (SETTLE), .TMO_W (TMO_W)
   ) dut (
      .clk_dut      (clk_dut),
      .reset        (reset),
      .i_start      (i_start),
      .i_num_tests  (i_num_tests),
      .i_dut_delay  (i_dut_delay),
      .i_dut_out    (i_dut_out),
      .i_ref_out    (i_ref_out),
      .i_delayed_a  (i_delayed_a),
      .i_delayed_b  (i_delayed_b),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_pass       (o_pass),
      .o_timeout    (o_timeout),
      .o_test_count (o_test_count),
      .o_err_count  (o_err_count)
`ifdef FAIL_CAPTURE_EN
      ,
      .o_fail_a     (o_fail_a),
      .o_fail_b     (o_fail_b),
      .o_fail_out   (o_fail_out),
      .o_fail_ref   (o_fail_ref),
      .o_fail_idx   (o_fail_idx)
`endif
   );

`ifndef FAIL_CAPTURE_EN
   assign o_fail_a   = '0;
   assign o_fail_b   = '0;
   assign o_fail_out = '0;
   assign o_fail_ref = '0;
   assign o_fail_idx = '0;
`endif

   always #5 clk_dut = ~clk_dut;

   typedef struct {
      logic [63:0]      count;
      logic [63:0]      err;
      logic             pass;
      logic             tmo;
      int               busy;
      logic [CNT_W-1:0] fidx;
      logic [WIDTH-1:0] fa, fb, fo, fr;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   armed    = 1'b0;

   bit               mism  [MAXN];
   logic [WIDTH-1:0] ref_a [MAXN];
   logic [WIDTH-1:0] dut_a [MAXN];
   logic [WIDTH-1:0] opa_a [MAXN];
   logic [WIDTH-1:0] opb_a [MAXN];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Monitor: pops one expectation per completed run
   // -------------------------------------------------------------------------
   initial begin
      exp_t e;
      int   busy_cnt;
      int   cyc;
      busy_cnt = 0;
      cyc      = 0;
      forever begin
         @(negedge clk_dut);
         if (!armed) begin
            busy_cnt = 0;
            cyc      = 0;
         end else begin
            cyc++;
            if (o_busy) busy_cnt++;
            if (o_done) begin
               if (sb_q.size() == 0) begin
                  check("scoreboard_empty", 64'(1), 64'(0));
               end else begin
                  e = sb_q.pop_front();
                  check("test_count", 64'(o_test_count), e.count);
                  check("err_count",  64'(o_err_count),  e.err);
                  check("pass",       64'(o_pass),       64'(e.pass));
                  check("timeout",    64'(o_timeout),    64'(e.tmo));
                  check("busy_cycles", 64'(busy_cnt),    64'(e.busy));
                  check("done_latency", 64'(cyc),        64'(e.busy + 1));
`ifdef FAIL_CAPTURE_EN
                  check("fail_idx",  64'(o_fail_idx), 64'(e.fidx));
                  check("fail_a",    64'(o_fail_a),   64'(e.fa));
                  check("fail_b",    64'(o_fail_b),   64'(e.fb));
                  check("fail_out",  64'(o_fail_out), 64'(e.fo));
                  check("fail_ref",  64'(o_fail_ref), 64'(e.fr));
`endif
               end
               armed    = 1'b0;
               busy_cnt = 0;
               cyc      = 0;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic drive_idle();
      i_start     = 1'b0;
      i_num_tests = '0;
      i_dut_delay = '1;
      i_dut_out   = '0;
      i_ref_out   = '0;
      i_delayed_a = '0;
      i_delayed_b = '0;
   endtask

   // Cycle t counts from the first cycle after the accepted start.
   // Outside the compare window dut and ref disagree on purpose.
   task automatic drive_cycle(input int t, input int r, input int n, input int v,
                              input int d, input bit tmo_case);
      i_dut_delay = (!tmo_case && t >= v) ? WIDTH'(d) : '1;
      i_num_tests = CNT_W'($urandom);
      if (!tmo_case && t >= r && t < r + n) begin
         i_ref_out   = ref_a[t-r];
         i_dut_out   = dut_a[t-r];
         i_delayed_a = opa_a[t-r];
         i_delayed_b = opb_a[t-r];
      end else begin
         i_dut_out   = $urandom;
         i_ref_out   = ~i_dut_out;
         i_delayed_a = $urandom;
         i_delayed_b = $urandom;
      end
   endtask

   task automatic clear_mism();
      for (int k = 0; k < MAXN; k++) mism[k] = 1'b0;
   endtask

   // One complete run; v = CAL cycles before the delay becomes valid.
   task automatic do_run(input int n, input int v, input int d, input bit tmo_case,
                         input bit poke);
      exp_t e;
      int   r, m, first, poke_t;
      r     = (v + 1) + (d + SETTLE + 1);
      m     = 0;
      first = -1;
      for (int k = 0; k < n; k++) begin
         ref_a[k] = $urandom;
         opa_a[k] = $urandom;
         opb_a[k] = $urandom;
         dut_a[k] = mism[k] ? (ref_a[k] ^ (WIDTH'(1) << $urandom_range(WIDTH-1, 0)))
                            : ref_a[k];
         if (mism[k]) begin
            m++;
            if (first < 0) first = k;
         end
      end
      e.fidx = '0; e.fa = '0; e.fb = '0; e.fo = '0; e.fr = '0;
      if (n == 0) begin
         e.count = 0; e.err = 0; e.pass = 1'b1; e.tmo = 1'b0; e.busy = 0;
      end else if (tmo_case) begin
         e.count = 0; e.err = 0; e.pass = 1'b0; e.tmo = 1'b1; e.busy = TMO_CYCLES;
      end else begin
         e.count = 64'(n);
         e.err   = 64'((m > ERR_MAX) ? ERR_MAX : m);
         e.pass  = (m == 0);
         e.tmo   = 1'b0;
         e.busy  = r + n;
         if (first >= 0) begin
            e.fidx = CNT_W'(first);
            e.fa = opa_a[first]; e.fb = opb_a[first];
            e.fo = dut_a[first]; e.fr = ref_a[first];
         end
      end
      sb_q.push_back(e);

      poke_t = -1;
      if (poke && n != 0) begin
         poke_t = tmo_case ? $urandom_range(TMO_CYCLES - 2, 0) : $urandom_range(r + n - 1, 0);
      end

      i_start     = 1'b1;
      i_num_tests = CNT_W'(n);
      @(posedge clk_dut); #1;
      i_start = 1'b0;
      armed   = 1'b1;
      for (int t = 0; armed && t < BUDGET; t++) begin
         drive_cycle(t, r, n, v, d, tmo_case);
         i_start = (t == poke_t);
         @(posedge clk_dut); #1;
      end
      if (armed) begin
         check("done_within_budget", 64'(0), 64'(1));
         armed = 1'b0;
         sb_q.delete();
      end
      drive_idle();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},    64'(o_busy),       64'(0));
      check({tag, "_done"},    64'(o_done),       64'(0));
      check({tag, "_pass"},    64'(o_pass),       64'(0));
      check({tag, "_timeout"}, 64'(o_timeout),    64'(0));
      check({tag, "_count"},   64'(o_test_count), 64'(0));
      check({tag, "_err"},     64'(o_err_count),  64'(0));
   endtask

   // -------------------------------------------------------------------------
   // Test sequence
   // -------------------------------------------------------------------------
   initial begin
      int r;
      drive_idle();
      reset = 1'b1;
      #23;
      check_outputs_zero("reset");
      @(negedge clk_dut);
      reset = 1'b0;
      @(posedge clk_dut); #1;

      // Zero-length run from IDLE: done next cycle, busy never seen.
      clear_mism();
      do_run(0, 0, 0, 1'b0, 1'b0);

      // Clean run: delay 5 valid on the 11th CAL cycle, 100 compares.
      do_run(100, 10, 5, 1'b0, 1'b0);

      // Same run with mismatches on compares 7, 20, 55.
      mism[6] = 1'b1; mism[19] = 1'b1; mism[54] = 1'b1;
      do_run(100, 10, 5, 1'b0, 1'b0);

      // Calibration timeout, then restart from DONE clears the flag.
      clear_mism();
      do_run(40, 0, 0, 1'b1, 1'b0);
      do_run(10, 0, 0, 1'b0, 1'b0);

      // Saturation: 20 consecutive mismatches.
      for (int k = 0; k < 20; k++) mism[k] = 1'b1;
      do_run(25, 2, 1, 1'b0, 1'b0);

      // Zero-length restart from DONE clears the counts.
      clear_mism();
      do_run(0, 0, 0, 1'b0, 1'b0);

      // Timeout with a stray start while busy.
      do_run(7, 0, 0, 1'b1, 1'b1);

      // Randomized runs with occasional starts while busy.
      for (int i = 0; i < 14; i++) begin
         int n;
         n = $urandom_range(60, 1);
         clear_mism();
         for (int k = 0; k < n; k++) mism[k] = ($urandom_range(9, 0) == 0);
         do_run(n, $urandom_range(15, 0), $urandom_range(20, 0), 1'b0, $urandom_range(1, 0) == 1);
      end

      // Reset in the middle of RUN aborts at once.
      clear_mism();
      for (int k = 0; k < 50; k++) begin
         ref_a[k] = $urandom; dut_a[k] = ref_a[k] ^ 32'h1; opa_a[k] = '0; opb_a[k] = '0;
      end
      r = (2 + 1) + (3 + SETTLE + 1);
      i_start     = 1'b1;
      i_num_tests = CNT_W'(50);
      @(posedge clk_dut); #1;
      i_start = 1'b0;
      for (int t = 0; t < r + 5; t++) begin
         drive_cycle(t, r, 50, 2, 3, 1'b0);
         @(posedge clk_dut); #1;
      end
      check("abort_busy_before", 64'(o_busy),       64'(1));
      check("abort_count_before", 64'(o_test_count), 64'(5));
      check("abort_err_before",  64'(o_err_count),  64'(5));
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("abort");
      @(negedge clk_dut);
      reset = 1'b0;
      drive_idle();
      @(posedge clk_dut); #1;

      // Fresh run after the abort.
      mism[3] = 1'b1;
      do_run(12, 1, 2, 1'b0, 1'b1);

      repeat (3) @(posedge clk_dut);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
